// File: rtl/vi_rst_pkg.sv
// Shared types and constants for the reset sequencer.
package vi_rst_pkg;

  typedef enum logic [1:0] {
    ASSERT    = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } rstStateT;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_SW   = 2'b10;
  localparam logic [7:0] CNT_MAX    = 8'hFF;

  // Counter width for a modulus n; never narrower than one bit.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vi_bit_sync.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module vi_bit_sync (
  input  logic iCLK,
  input  logic iRST_ASYNC_N,
  input  logic iD,
  output logic oQ
);

  logic meta;

  // Metastability filter: first stage captures, second stage presents.
  always_ff @(posedge iCLK or negedge iRST_ASYNC_N) begin
    if (!iRST_ASYNC_N) begin
      meta <= 1'b0;
      oQ   <= 1'b0;
    end else begin
      meta <= iD;
      oQ   <= meta;
    end
  end

endmodule

// File: rtl/vi_rst_seq.sv
// Reset sequencer: holds all domains in reset, waits for a stable PLL lock,
// then releases domains in index order with fixed spacing.
module vi_rst_seq
  import vi_rst_pkg::*;
#(
  parameter int NUM_DOM   = 4,
  parameter int HOLD_CYC  = 64,
  parameter int LOCK_FILT = 8,
  parameter int STEP_CYC  = 16
) (
  input  logic               iCLK,
  input  logic               iRST_ASYNC_N,
  input  logic               iPLL_LOCKED,
  input  logic               iSW_RST,
  output logic [NUM_DOM-1:0] oRST_N,
  output logic               oRST_DONE,
  output logic [1:0]         oRST_CAUSE,
  output logic [7:0]         oRST_CNT
);

  localparam int HW = cntWidth(HOLD_CYC);
  localparam int FW = cntWidth(LOCK_FILT);
  localparam int SW = cntWidth(STEP_CYC);
  localparam int IW = $clog2(NUM_DOM) + 1;

  rstStateT        state;
  logic [HW-1:0]   holdCnt;
  logic [FW-1:0]   filtCnt;
  logic [SW-1:0]   stepCnt;
  logic [IW-1:0]   idx;
  logic            lockS;
  logic            lockLoss;
  logic            abortReq;

  vi_bit_sync uLockSync (
    .iCLK         (iCLK),
    .iRST_ASYNC_N (iRST_ASYNC_N),
    .iD           (iPLL_LOCKED),
    .oQ           (lockS)
  );

  // Lock loss only aborts once release has begun; software aborts anywhere past ASSERT.
  assign lockLoss = ~lockS & ((state == RELEASE) | (state == RUN));
  assign abortReq = (state != ASSERT) & (iSW_RST | lockLoss);

  // Sequencer FSM with registered reset outputs and event bookkeeping.
  always_ff @(posedge iCLK or negedge iRST_ASYNC_N) begin
    if (!iRST_ASYNC_N) begin
      state      <= ASSERT;
      holdCnt    <= '0;
      filtCnt    <= '0;
      stepCnt    <= '0;
      idx        <= '0;
      oRST_N     <= '0;
      oRST_DONE  <= 1'b0;
      oRST_CAUSE <= CAUSE_POR;
      oRST_CNT   <= 8'd0;
    end else if (abortReq) begin
      state      <= ASSERT;
      holdCnt    <= '0;
      oRST_N     <= '0;
      oRST_DONE  <= 1'b0;
      oRST_CAUSE <= iSW_RST ? CAUSE_SW : CAUSE_LOCK;
      if (oRST_CNT != CNT_MAX) begin
        oRST_CNT <= oRST_CNT + 8'd1;
      end
    end else begin
      case (state)
        ASSERT: begin
          oRST_N    <= '0;
          oRST_DONE <= 1'b0;
          if (iSW_RST) begin
            holdCnt <= '0;
          end else if (holdCnt == HW'(HOLD_CYC - 1)) begin
            state   <= WAIT_LOCK;
            filtCnt <= '0;
          end else begin
            holdCnt <= holdCnt + HW'(1);
          end
        end
        WAIT_LOCK: begin
          if (!lockS) begin
            filtCnt <= '0;
          end else if (filtCnt == FW'(LOCK_FILT - 1)) begin
            state   <= RELEASE;
            idx     <= '0;
            stepCnt <= '0;
          end else begin
            filtCnt <= filtCnt + FW'(1);
          end
        end
        RELEASE: begin
          if (stepCnt == SW'(STEP_CYC - 1)) begin
            stepCnt <= '0;
            idx     <= idx + IW'(1);
            for (int d = 0; d < NUM_DOM; d++) begin
              if (idx == IW'(d)) begin
                oRST_N[d] <= 1'b1;
              end
            end
            if (idx == IW'(NUM_DOM - 1)) begin
              state     <= RUN;
              oRST_DONE <= 1'b1;
            end
          end else begin
            stepCnt <= stepCnt + SW'(1);
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state     <= ASSERT;
          holdCnt   <= '0;
          oRST_N    <= '0;
          oRST_DONE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vi_rst_seq.sv
// Self-checking bench for vi_rst_seq: directed scenarios plus random traffic
// compared every cycle against an elapsed-time reference model.
module tb_vi_rst_seq;

  localparam int NUM_DOM   = 4;
  localparam int HOLD_CYC  = 64;
  localparam int LOCK_FILT = 8;
  localparam int STEP_CYC  = 16;
  localparam int PH_ASSERT = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_REL    = 2;
  localparam int PH_RUN    = 3;

  logic               iCLK = 1'b0;
  logic               iRST_ASYNC_N;
  logic               iPLL_LOCKED;
  logic               iSW_RST;
  logic [NUM_DOM-1:0] oRST_N;
  logic               oRST_DONE;
  logic [1:0]         oRST_CAUSE;
  logic [7:0]         oRST_CNT;

  int nTests = 0;
  int nFail  = 0;

  // Reference model: phase plus edges elapsed in it; lock seen two edges late.
  int mPhase, mQuiet, mFilt, mRelAge, mCause, mCnt, mP1, mP2;
  bit rlk;

  vi_rst_seq #(
    .NUM_DOM   (NUM_DOM),
    .HOLD_CYC  (HOLD_CYC),
    .LOCK_FILT (LOCK_FILT),
    .STEP_CYC  (STEP_CYC)
  ) dut (
    .iCLK         (iCLK),
    .iRST_ASYNC_N (iRST_ASYNC_N),
    .iPLL_LOCKED  (iPLL_LOCKED),
    .iSW_RST      (iSW_RST),
    .oRST_N       (oRST_N),
    .oRST_DONE    (oRST_DONE),
    .oRST_CAUSE   (oRST_CAUSE),
    .oRST_CNT     (oRST_CNT)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPhase = PH_ASSERT; mQuiet = 0; mFilt = 0; mRelAge = 0;
    mCause = 0; mCnt = 0; mP1 = 0; mP2 = 0;
  endtask

  task automatic modelEdge(input bit sw, input bit lk);
    int ls;
    bit abort;
    ls  = mP2;
    mP2 = mP1;
    mP1 = int'(lk);
    if (mPhase == PH_ASSERT) begin
      if (sw) mQuiet = 0;
      else begin
        mQuiet++;
        if (mQuiet == HOLD_CYC) begin mPhase = PH_WAIT; mFilt = 0; end
      end
    end else begin
      abort = sw || (ls == 0 && mPhase >= PH_REL);
      if (abort) begin
        mPhase = PH_ASSERT;
        mQuiet = 0;
        mCause = sw ? 2 : 1;
        mCnt   = (mCnt < 255) ? mCnt + 1 : 255;
      end else if (mPhase == PH_WAIT) begin
        mFilt = (ls != 0) ? mFilt + 1 : 0;
        if (mFilt == LOCK_FILT) begin mPhase = PH_REL; mRelAge = 0; end
      end else if (mPhase == PH_REL) begin
        mRelAge++;
        if (mRelAge == NUM_DOM * STEP_CYC) mPhase = PH_RUN;
      end
    end
  endtask

  function automatic logic [31:0] expRstN();
    if (mPhase == PH_RUN) return (32'd1 << NUM_DOM) - 32'd1;
    if (mPhase == PH_REL) return (32'd1 << (mRelAge / STEP_CYC)) - 32'd1;
    return 32'd0;
  endfunction

  task automatic checkModel();
    chk("rstN",  32'(oRST_N),     expRstN());
    chk("done",  32'(oRST_DONE),  (mPhase == PH_RUN) ? 32'd1 : 32'd0);
    chk("cause", 32'(oRST_CAUSE), 32'(mCause));
    chk("cnt",   32'(oRST_CNT),   32'(mCnt));
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, check at negedge.
  task automatic cyc(input bit sw, input bit lk);
    iSW_RST     = sw;
    iPLL_LOCKED = lk;
    @(posedge iCLK);
    modelEdge(sw, lk);
    @(negedge iCLK);
    checkModel();
  endtask

  initial begin
    iRST_ASYNC_N = 1'b0;
    iSW_RST      = 1'b0;
    iPLL_LOCKED  = 1'b1;
    modelReset();
    #12;
    chk("por_rstN",  32'(oRST_N),     32'd0);
    chk("por_done",  32'(oRST_DONE),  32'd0);
    chk("por_cause", 32'(oRST_CAUSE), 32'd0);
    chk("por_cnt",   32'(oRST_CNT),   32'd0);
    @(negedge iCLK);
    iRST_ASYNC_N = 1'b1;

    // Power-up with lock held high: releases at 88/104/120/136.
    for (int e = 1; e <= 140; e++) begin
      cyc(1'b0, 1'b1);
      case (e)
        87:  chk("s1_e87",  32'(oRST_N), 32'h0);
        88:  chk("s1_e88",  32'(oRST_N), 32'h1);
        103: chk("s1_e103", 32'(oRST_N), 32'h1);
        104: chk("s1_e104", 32'(oRST_N), 32'h3);
        120: chk("s1_e120", 32'(oRST_N), 32'h7);
        135: chk("s1_done135", 32'(oRST_DONE), 32'd0);
        136: begin
          chk("s1_e136",  32'(oRST_N),    32'hF);
          chk("s1_done",  32'(oRST_DONE), 32'd1);
        end
        default: ;
      endcase
    end
    chk("s1_cnt", 32'(oRST_CNT), 32'd0);

    // Lock drop in RUN: reset appears on the third edge.
    cyc(1'b0, 1'b0);
    chk("s3_t1", 32'(oRST_N), 32'hF);
    cyc(1'b0, 1'b0);
    chk("s3_t2", 32'(oRST_N), 32'hF);
    cyc(1'b0, 1'b0);
    chk("s3_t3",     32'(oRST_N),     32'h0);
    chk("s3_done",   32'(oRST_DONE),  32'd0);
    chk("s3_cause",  32'(oRST_CAUSE), 32'd1);
    chk("s3_cnt",    32'(oRST_CNT),   32'd1);
    repeat (150) cyc(1'b0, 1'b1);
    chk("s3_reseq", 32'(oRST_DONE), 32'd1);

    // Lock glitch in WAIT_LOCK restarts the filter.
    cyc(1'b1, 1'b1);
    chk("s2_cause", 32'(oRST_CAUSE), 32'd2);
    repeat (70) cyc(1'b0, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      cyc(1'b0, (k == 6) ? 1'b0 : 1'b1);
      if (k == 31) chk("s2_k31", 32'(oRST_N), 32'h0);
      if (k == 32) chk("s2_k32", 32'(oRST_N), 32'h1);
    end
    chk("s2_cnt", 32'(oRST_CNT), 32'd2);

    // Software reset plus lock drop right after domain 1 releases.
    for (int k = 0; k < 60 && oRST_N != 4'h3; k++) cyc(1'b0, 1'b1);
    chk("s4_dom1", 32'(oRST_N), 32'h3);
    cyc(1'b1, 1'b0);
    chk("s4_rstN",  32'(oRST_N),     32'h0);
    chk("s4_cause", 32'(oRST_CAUSE), 32'd2);
    chk("s4_cnt",   32'(oRST_CNT),   32'd3);

    // Long software hold in ASSERT: full hold counted from its falling edge.
    repeat (100) cyc(1'b1, 1'b1);
    for (int k = 1; k <= 90; k++) begin
      cyc(1'b0, 1'b1);
      if (k == 87) chk("s5_k87", 32'(oRST_N), 32'h0);
      if (k == 88) chk("s5_k88", 32'(oRST_N), 32'h1);
    end
    chk("s5_cnt", 32'(oRST_CNT), 32'd3);

    // Random traffic: rare software requests, occasional short lock outages.
    rlk = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (rlk) begin
        if ($urandom_range(0, 399) == 0) rlk = 1'b0;
      end else begin
        if ($urandom_range(0, 9) == 0) rlk = 1'b1;
      end
      cyc($urandom_range(0, 299) == 0, rlk);
    end

    // Many software resets saturate the event counter.
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, 1'b1);
      repeat (66) cyc(1'b0, 1'b1);
    end
    chk("s6_sat",   32'(oRST_CNT),   32'd255);
    chk("s6_cause", 32'(oRST_CAUSE), 32'd2);

    // Power-on reset mid-RELEASE clears everything without a clock edge.
    repeat (30) cyc(1'b0, 1'b1);
    chk("s6_midrel", 32'(oRST_N), 32'h1);
    @(posedge iCLK);
    #2;
    iRST_ASYNC_N = 1'b0;
    #1;
    chk("s6_por_rstN",  32'(oRST_N),     32'd0);
    chk("s6_por_done",  32'(oRST_DONE),  32'd0);
    chk("s6_por_cause", 32'(oRST_CAUSE), 32'd0);
    chk("s6_por_cnt",   32'(oRST_CNT),   32'd0);
    modelReset();
    @(negedge iCLK);
    iRST_ASYNC_N = 1'b1;
    repeat (140) cyc(1'b0, 1'b1);
    chk("s6_reseq", 32'(oRST_DONE), 32'd1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
